// File: rtl/tx_link_pkg.sv
// tx_link_pkg: shared constants, FSM state type and byte-window helper for the transmit framer.
package tx_link_pkg;

    localparam int LINK_WIDTH = 64;
    localparam int LANES      = LINK_WIDTH / 8;

    localparam logic [LINK_WIDTH-1:0] DEF_TRAIN_PATTERN = 64'hBC50_BC50_BC50_BC50;
    localparam logic [LINK_WIDTH-1:0] DEF_IDLE_WORD     = 64'h0707_0707_0707_0707;

    typedef enum logic {TRAIN, DATA} state_t;

    // Selects {sw, prev}[127-8k -: 64]: the stream delayed by k bytes.
    function automatic logic [LINK_WIDTH-1:0] byte_window(
        input logic [LINK_WIDTH-1:0] sw,
        input logic [LINK_WIDTH-1:0] prev,
        input logic [2:0]            k
    );
        logic [2*LINK_WIDTH-1:0] c;
        logic [6:0]              sh;
        c  = {sw, prev};
        sh = 7'((LANES - int'(k)) * 8);
        return LINK_WIDTH'(c >> sh);
    endfunction

endpackage

// File: rtl/byte_skew.sv
// byte_skew: two-word stream buffer with registered byte-window output and training flag.
module byte_skew
    import tx_link_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LINK_WIDTH-1:0] w,
    input  logic [2:0]            k,
    input  logic                  tf,
    output logic [LINK_WIDTH-1:0] dout,
    output logic                  training
);

    logic [LINK_WIDTH-1:0] r_sw;
    logic [LINK_WIDTH-1:0] r_prev;
    logic                  r_tf;
    logic                  r_tp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw     <= '0;
            r_prev   <= '0;
            r_tf     <= 1'b0;
            r_tp     <= 1'b0;
            dout     <= '0;
            training <= 1'b0;
        end else begin
            r_sw     <= w;
            r_prev   <= r_sw;
            r_tf     <= tf;
            r_tp     <= r_tf;
            dout     <= byte_window(r_sw, r_prev, k);
            // With a skew, an output word can carry bytes of the older word too.
            training <= (k == 3'd0) ? r_tf : (r_tf | r_tp);
        end
    end

endmodule

// File: rtl/tx_align_framer.sv
// tx_align_framer: training-sequence generator and payload/idle framer with optional byte pre-skew.
module tx_align_framer
    import tx_link_pkg::*;
#(
    parameter int               WIDTH         = LINK_WIDTH,
    parameter int               TRAIN_WORDS   = 16,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter logic [WIDTH-1:0] IDLE_WORD     = DEF_IDLE_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bypass,
    input  logic [2:0]       offset,
    input  logic             train_req,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] dout,
    output logic             training
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [WIDTH-1:0] w_word;
    logic [2:0]       w_k;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= bypass ? DATA : TRAIN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        if (bypass) begin
            w_state_nxt = DATA;
        end else if (r_state == TRAIN) begin
            if (!train_req && r_cnt == 8'(TRAIN_WORDS - 1))
                w_state_nxt = DATA;
            else if (!train_req)
                w_cnt_nxt = r_cnt + 8'd1;
        end else if (train_req) begin
            w_state_nxt = TRAIN;
        end
    end

    assign s_ready = (r_state == DATA);
    assign w_word  = (r_state == TRAIN) ? TRAIN_PATTERN : (s_valid ? s_data : IDLE_WORD);
    assign w_k     = bypass ? 3'd0 : offset;

    byte_skew u_skew (
        .clk      (clk),
        .rst      (rst),
        .w        (w_word),
        .k        (w_k),
        .tf       (r_state == TRAIN),
        .dout     (dout),
        .training (training)
    );

endmodule

// File: doc/tx_align_framer.md
# tx_align_framer

Transmit-side framer feeding the 64-bit parallel word into the serializer. After reset or on request, it sends a fixed-length training sequence the far-end receiver uses to find byte alignment. It then forwards payload words under a valid/ready handshake, inserting an idle word when no payload is offered. An optional programmable byte pre-skew delays the outgoing stream by 0–7 bytes, which lets the link be characterised against the receiver's fixed byte-shift stage.

## Interface
Parameters:
- WIDTH, 64, word width in bits; must be 64 (8 byte lanes).
- TRAIN_WORDS, 16, number of training words per training sequence; minimum 1, maximum 255.
- TRAIN_PATTERN, 64'hBC50_BC50_BC50_BC50, word emitted during training.
- IDLE_WORD, 64'h0707_0707_0707_0707, word emitted in DATA when no payload is accepted.

Ports:
- clk  in  1  single clock domain; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- bypass  in  1  1 = no training, no pre-skew, pure payload/idle pass-through.
- offset  in  3  byte pre-skew k (0–7), sampled every cycle.
- train_req  in  1  single-cycle pulse that starts a new training sequence.
- s_data  in  64  payload word.
- s_valid  in  1  payload word present.
- s_ready  out  1  framer accepts s_data this cycle.
- dout  out  64  registered word to the serializer.
- training  out  1  registered; 1 when dout carries a training-stream word.

## Operation
- FSM states: TRAIN and DATA. A training-word counter cnt is 8 bits wide.
- Reset puts the FSM in TRAIN with cnt=0. If bypass=1, the FSM goes to DATA instead.
- TRAIN state:
  - The stream word w is TRAIN_PATTERN.
  - s_ready=0.
  - cnt increments each cycle.
  - When cnt reaches TRAIN_WORDS-1, the next state is DATA and cnt clears.
- DATA state:
  - s_ready=1.
  - If s_valid=1, then w=s_data and the word is accepted. Otherwise w=IDLE_WORD.
- train_req=1 in DATA: the next state is TRAIN with cnt=0. A payload word offered in that same cycle is still accepted.
- train_req=1 in TRAIN: cnt restarts at 0, so the sequence is extended.
- bypass=1 has three effects:
  - train_req is ignored.
  - The FSM is forced to DATA on the next edge, aborting any training in progress.
  - The effective k is 0.
- s_ready is combinational from state (DATA) only. It does not depend on s_valid.
- Pipeline registers:
  - sw <= w every cycle.
  - prev <= sw.
  - tf <= (state==TRAIN).
  - tp <= tf.
- Output:
  - Form C = {sw, prev}, 128 bits, with sw in the upper half.
  - dout <= C[127-8k -: 64].
  - k=0 gives dout <= sw.
  - k=3 gives dout <= {sw[39:0], prev[63:40]}.
- training <= tf when k=0, or tf|tp when k≠0. The flag is asserted for any output word containing a training byte.

## Timing
- Reset values: dout=0, training=0, sw=0, prev=0, tf=0, tp=0, state=TRAIN (or DATA if bypass=1), cnt=0.
- s_ready is 0 during the reset cycle and for the first TRAIN_WORDS cycles after reset is released.
- Latency: a word accepted (or generated) in cycle n appears on dout after the edge ending cycle n+1. That is 2 clocks for k=0. With k≠0, its upper k bytes spill into the following output word.
- Changing offset takes effect on the next dout edge. The transition word mixes bytes per the new k. No flush occurs.
- A training sequence is exactly TRAIN_WORDS consecutive TRAIN_PATTERN words on dout (k=0). The first payload or idle word follows with no gap.
- Reset asserted mid-operation: all registers take their reset values on that edge, and any partially sent sequence is dropped.
- train_req and reset in the same cycle: reset wins.

## Structure
- Shared package tx_link_pkg holds:
  - WIDTH and the byte-lane count (8).
  - The default TRAIN_PATTERN and IDLE_WORD constants.
  - The FSM state enum (TRAIN, DATA).
  - A function computing the byte-window select from {sw, prev} and k.
- One sub-module, byte_skew: the sw/prev buffer plus the registered 8:1 byte-window mux. It has inputs clk, rst, w, k, tf and outputs dout and training. The FSM and handshake stay in tx_align_framer.

## Test plan
- Reset release, TRAIN_WORDS=16, k=0, s_valid=0 -> 16 dout words of BC50_BC50_BC50_BC50 with training=1, then 0707…07 with training=0. s_ready first rises in cycle 16 after reset release.
- DATA with k=0, s_valid=1 for payload words 64'h0001…, 64'h0002…, 64'h0003… -> dout matches each word 2 clocks later, with no idle words inserted between them.
- k=3, stream A=64'h1111_2222_3333_4444 then B=64'h5555_6666_7777_8888 -> the dout word after B is {B[39:0], A[63:40]} = 64'h6677_7788_8811_1122.
- train_req pulsed with s_valid=1 carrying 64'hDEAD_BEEF_0000_0001 -> that word is accepted and appears on dout, followed by exactly 16 training words. s_ready is 0 for those 16 cycles.
- bypass=1 asserted mid-TRAIN with offset=5 -> the FSM is in DATA on the next edge and s_ready=1. Subsequent dout words equal the inputs unshifted. train_req pulses are ignored.
- Reset asserted while in DATA with payload flowing -> dout=0 and training=0 on the next edge, then a full training sequence follows reset release.
